// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types; the branch-tracking entry used by the
// predictor resolution queue lives here.
package rv32i_types;

    typedef struct packed {
        logic [31:0] pc;
        logic        p_tnt;
    } bp_entry_t;

    localparam int unsigned BP_DEPTH_DEFAULT = 4;

    function automatic logic [31:0] bp_fetch_target(
        input logic        taken,
        input logic [31:0] target,
        input logic [31:0] pc
    );
        return taken ? target : pc + 32'd4;
    endfunction

endpackage

// File: rtl/bp_resolve_queue_if.sv
// IF-side push, EX-side resolve and predictor/pipeline feedback signals
// of the branch resolution queue.
interface bp_resolve_queue_if;

    logic        if_push;
    logic [31:0] if_pc;
    logic        if_p_tnt;
    logic        ex_valid;
    logic [31:0] ex_pc_in;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        full;
    logic        empty;
    logic        update;
    logic [31:0] ex_pc;
    logic        prev_mispredict;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        proto_err;
    logic [31:0] br_count;
    logic [31:0] mp_count;

    modport master (
        output if_push, if_pc, if_p_tnt,
        output ex_valid, ex_pc_in, ex_taken, ex_target,
        input  full, empty, update, ex_pc, prev_mispredict,
        input  flush, redirect_pc, proto_err, br_count, mp_count
    );

    modport slave (
        input  if_push, if_pc, if_p_tnt,
        input  ex_valid, ex_pc_in, ex_taken, ex_target,
        output full, empty, update, ex_pc, prev_mispredict,
        output flush, redirect_pc, proto_err, br_count, mp_count
    );

endinterface

// File: rtl/bp_track_fifo.sv
// Circular buffer of in-flight predictions with push, pop and synchronous
// clear; head entry, full and empty derive from registered state.
module bp_track_fifo
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH = BP_DEPTH_DEFAULT
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      clr,
    input  logic      push,
    input  bp_entry_t push_entry,
    input  logic      pop,
    output bp_entry_t head_entry,
    output logic      full,
    output logic      empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    bp_entry_t        mem [DEPTH];
    logic [AW-1:0]    head_q;
    logic [AW-1:0]    tail_q;
    logic [CW-1:0]    count_q;

    assign head_entry = mem[head_q];
    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem[tail_q] <= push_entry;
                tail_q      <= tail_q + AW'(1);
            end
            if (pop) begin
                head_q <= head_q + AW'(1);
            end
            // Push and pop together (legal when full) leave the count unchanged.
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/bp_resolve_queue.sv
// Resolution end of the branch predictor: retires the oldest prediction at
// EX, emits predictor updates, mispredict flush/redirect and accuracy counters.
module bp_resolve_queue
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH = BP_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    bp_resolve_queue_if.slave bp
);

    bp_entry_t head_entry;
    bp_entry_t push_entry;
    logic      fifo_full;
    logic      fifo_empty;
    logic      resolve;
    logic      mis;
    logic      push_ok;
    logic      err_now;

    assign push_entry = '{pc: bp.if_pc, p_tnt: bp.if_p_tnt};

    always_comb begin
        resolve = bp.ex_valid && !fifo_empty;
        mis     = resolve && (head_entry.p_tnt ^ bp.ex_taken);
        // A push alongside a mispredicting resolve is wrong-path and dropped.
        push_ok = bp.if_push && (!fifo_full || resolve) && !mis;
        err_now = (bp.if_push && fifo_full && !resolve)
               || (bp.ex_valid && fifo_empty)
               || (resolve && (bp.ex_pc_in != head_entry.pc));
    end

    bp_track_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clr        (mis),
        .push       (push_ok),
        .push_entry (push_entry),
        .pop        (resolve),
        .head_entry (head_entry),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign bp.full  = fifo_full;
    assign bp.empty = fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            bp.update          <= 1'b0;
            bp.ex_pc           <= '0;
            bp.prev_mispredict <= 1'b0;
            bp.flush           <= 1'b0;
            bp.redirect_pc     <= '0;
            bp.proto_err       <= 1'b0;
            bp.br_count        <= '0;
            bp.mp_count        <= '0;
        end else begin
            bp.update          <= resolve;
            bp.prev_mispredict <= mis;
            bp.flush           <= mis;
            if (resolve) begin
                bp.ex_pc    <= bp.ex_pc_in;
                bp.br_count <= bp.br_count + 32'd1;
            end
            if (mis) begin
                bp.redirect_pc <= bp_fetch_target(bp.ex_taken, bp.ex_target, bp.ex_pc_in);
                bp.mp_count    <= bp.mp_count + 32'd1;
            end
            if (err_now) begin
                bp.proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Directed bench for bp_resolve_queue: reset, resolve/mispredict paths,
// full-queue behaviour, flush-vs-push priority and mid-run reset.
module tb_bp_resolve_queue;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    bp_resolve_queue_if bp ();

    bp_resolve_queue #(
        .DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bp.if_push   = 1'b0;
        bp.if_pc     = '0;
        bp.if_p_tnt  = 1'b0;
        bp.ex_valid  = 1'b0;
        bp.ex_pc_in  = '0;
        bp.ex_taken  = 1'b0;
        bp.ex_target = '0;
    endtask

    task automatic push(input logic [31:0] pc, input logic p);
        idle();
        bp.if_push  = 1'b1;
        bp.if_pc    = pc;
        bp.if_p_tnt = p;
        tick();
        idle();
    endtask

    task automatic test_reset;
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (bp.update !== 1'b0) begin bad++; $display("FAIL rst_update got=%0h exp=0", bp.update); end
        total++; if (bp.flush !== 1'b0) begin bad++; $display("FAIL rst_flush got=%0h exp=0", bp.flush); end
        total++; if (bp.proto_err !== 1'b0) begin bad++; $display("FAIL rst_proto_err got=%0h exp=0", bp.proto_err); end
        total++; if (bp.prev_mispredict !== 1'b0) begin bad++; $display("FAIL rst_prev_mis got=%0h exp=0", bp.prev_mispredict); end
        total++; if (bp.ex_pc !== 32'h0) begin bad++; $display("FAIL rst_ex_pc got=%0h exp=0", bp.ex_pc); end
        total++; if (bp.redirect_pc !== 32'h0) begin bad++; $display("FAIL rst_redirect got=%0h exp=0", bp.redirect_pc); end
        total++; if (bp.br_count !== 32'h0) begin bad++; $display("FAIL rst_br_count got=%0h exp=0", bp.br_count); end
        total++; if (bp.mp_count !== 32'h0) begin bad++; $display("FAIL rst_mp_count got=%0h exp=0", bp.mp_count); end
        total++; if (bp.empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%0h exp=1", bp.empty); end
        total++; if (bp.full !== 1'b0) begin bad++; $display("FAIL rst_full got=%0h exp=0", bp.full); end
    endtask

    task automatic test_correct;
        push(32'h100, 1'b1);
        total++; if (bp.empty !== 1'b0) begin bad++; $display("FAIL ok_empty_after_push got=%0h exp=0", bp.empty); end
        bp.ex_valid  = 1'b1;
        bp.ex_pc_in  = 32'h100;
        bp.ex_taken  = 1'b1;
        bp.ex_target = 32'h500;
        tick();
        idle();
        total++; if (bp.update !== 1'b1) begin bad++; $display("FAIL ok_update got=%0h exp=1", bp.update); end
        total++; if (bp.ex_pc !== 32'h100) begin bad++; $display("FAIL ok_ex_pc got=%0h exp=100", bp.ex_pc); end
        total++; if (bp.prev_mispredict !== 1'b0) begin bad++; $display("FAIL ok_prev_mis got=%0h exp=0", bp.prev_mispredict); end
        total++; if (bp.flush !== 1'b0) begin bad++; $display("FAIL ok_flush got=%0h exp=0", bp.flush); end
        total++; if (bp.br_count !== 32'd1) begin bad++; $display("FAIL ok_br_count got=%0d exp=1", bp.br_count); end
        total++; if (bp.empty !== 1'b1) begin bad++; $display("FAIL ok_empty got=%0h exp=1", bp.empty); end
        tick();
        total++; if (bp.update !== 1'b0) begin bad++; $display("FAIL ok_update_pulse got=%0h exp=0", bp.update); end
    endtask

    task automatic test_mispredict_taken;
        push(32'h200, 1'b0);
        bp.ex_valid  = 1'b1;
        bp.ex_pc_in  = 32'h200;
        bp.ex_taken  = 1'b1;
        bp.ex_target = 32'h300;
        tick();
        idle();
        total++; if (bp.flush !== 1'b1) begin bad++; $display("FAIL mt_flush got=%0h exp=1", bp.flush); end
        total++; if (bp.redirect_pc !== 32'h300) begin bad++; $display("FAIL mt_redirect got=%0h exp=300", bp.redirect_pc); end
        total++; if (bp.prev_mispredict !== 1'b1) begin bad++; $display("FAIL mt_prev_mis got=%0h exp=1", bp.prev_mispredict); end
        total++; if (bp.mp_count !== 32'd1) begin bad++; $display("FAIL mt_mp_count got=%0d exp=1", bp.mp_count); end
        total++; if (bp.br_count !== 32'd2) begin bad++; $display("FAIL mt_br_count got=%0d exp=2", bp.br_count); end
        total++; if (bp.empty !== 1'b1) begin bad++; $display("FAIL mt_empty got=%0h exp=1", bp.empty); end
        tick();
        total++; if (bp.flush !== 1'b0) begin bad++; $display("FAIL mt_flush_pulse got=%0h exp=0", bp.flush); end
    endtask

    task automatic test_mispredict_not_taken;
        push(32'h400, 1'b1);
        bp.ex_valid  = 1'b1;
        bp.ex_pc_in  = 32'h400;
        bp.ex_taken  = 1'b0;
        bp.ex_target = 32'h999;
        tick();
        idle();
        total++; if (bp.flush !== 1'b1) begin bad++; $display("FAIL mn_flush got=%0h exp=1", bp.flush); end
        total++; if (bp.redirect_pc !== 32'h404) begin bad++; $display("FAIL mn_redirect got=%0h exp=404", bp.redirect_pc); end
        total++; if (bp.mp_count !== 32'd2) begin bad++; $display("FAIL mn_mp_count got=%0d exp=2", bp.mp_count); end
        total++; if (bp.br_count !== 32'd3) begin bad++; $display("FAIL mn_br_count got=%0d exp=3", bp.br_count); end
        tick();
    endtask

    task automatic test_full_back_to_back;
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'h14;
        exp_pc[1] = 32'h18;
        exp_pc[2] = 32'h1C;
        exp_pc[3] = 32'h20;
        push(32'h10, 1'b1);
        push(32'h14, 1'b1);
        push(32'h18, 1'b1);
        total++; if (bp.full !== 1'b0) begin bad++; $display("FAIL fb_not_full3 got=%0h exp=0", bp.full); end
        push(32'h1C, 1'b1);
        total++; if (bp.full !== 1'b1) begin bad++; $display("FAIL fb_full got=%0h exp=1", bp.full); end
        bp.if_push  = 1'b1;
        bp.if_pc    = 32'h20;
        bp.if_p_tnt = 1'b1;
        bp.ex_valid = 1'b1;
        bp.ex_pc_in = 32'h10;
        bp.ex_taken = 1'b1;
        tick();
        idle();
        total++; if (bp.full !== 1'b1) begin bad++; $display("FAIL fb_still_full got=%0h exp=1", bp.full); end
        total++; if (bp.update !== 1'b1 || bp.ex_pc !== 32'h10) begin bad++; $display("FAIL fb_first_retire got=%0h/%0h exp=1/10", bp.update, bp.ex_pc); end
        total++; if (bp.proto_err !== 1'b0) begin bad++; $display("FAIL fb_no_err got=%0h exp=0", bp.proto_err); end
        for (int i = 0; i < 4; i++) begin
            bp.ex_valid = 1'b1;
            bp.ex_pc_in = exp_pc[i];
            bp.ex_taken = 1'b1;
            tick();
            total++;
            if (bp.update !== 1'b1 || bp.ex_pc !== exp_pc[i] || bp.proto_err !== 1'b0 || bp.flush !== 1'b0) begin
                bad++;
                $display("FAIL fb_order[%0d] upd=%0h pc=%0h err=%0h fl=%0h exp=1/%0h/0/0", i, bp.update, bp.ex_pc, bp.proto_err, bp.flush, exp_pc[i]);
            end
        end
        idle();
        total++; if (bp.empty !== 1'b1) begin bad++; $display("FAIL fb_drained got=%0h exp=1", bp.empty); end
        total++; if (bp.br_count !== 32'd8) begin bad++; $display("FAIL fb_br_count got=%0d exp=8", bp.br_count); end

        push(32'h30, 1'b0);
        push(32'h34, 1'b0);
        push(32'h38, 1'b0);
        push(32'h3C, 1'b0);
        push(32'h40, 1'b0);
        total++; if (bp.proto_err !== 1'b1) begin bad++; $display("FAIL fb_overflow_err got=%0h exp=1", bp.proto_err); end
        total++; if (bp.full !== 1'b1) begin bad++; $display("FAIL fb_overflow_full got=%0h exp=1", bp.full); end
        for (int i = 0; i < 4; i++) begin
            bp.ex_valid = 1'b1;
            bp.ex_pc_in = 32'h30 + 32'(4 * i);
            bp.ex_taken = 1'b0;
            tick();
        end
        idle();
        total++; if (bp.empty !== 1'b1) begin bad++; $display("FAIL fb_dropped_entry got=%0h exp=1", bp.empty); end
        total++; if (bp.br_count !== 32'd12) begin bad++; $display("FAIL fb_br_count2 got=%0d exp=12", bp.br_count); end
        total++; if (bp.mp_count !== 32'd2) begin bad++; $display("FAIL fb_mp_count got=%0d exp=2", bp.mp_count); end
    endtask

    task automatic test_flush_beats_push;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        push(32'h50, 1'b1);
        push(32'h54, 1'b1);
        bp.if_push  = 1'b1;
        bp.if_pc    = 32'h58;
        bp.if_p_tnt = 1'b1;
        bp.ex_valid = 1'b1;
        bp.ex_pc_in = 32'h50;
        bp.ex_taken = 1'b0;
        tick();
        idle();
        total++; if (bp.flush !== 1'b1) begin bad++; $display("FAIL fp_flush got=%0h exp=1", bp.flush); end
        total++; if (bp.redirect_pc !== 32'h54) begin bad++; $display("FAIL fp_redirect got=%0h exp=54", bp.redirect_pc); end
        total++; if (bp.empty !== 1'b1) begin bad++; $display("FAIL fp_empty got=%0h exp=1", bp.empty); end
        total++; if (bp.proto_err !== 1'b0) begin bad++; $display("FAIL fp_no_err got=%0h exp=0", bp.proto_err); end
        bp.ex_valid = 1'b1;
        bp.ex_pc_in = 32'h54;
        bp.ex_taken = 1'b1;
        tick();
        idle();
        total++; if (bp.update !== 1'b0) begin bad++; $display("FAIL fp_stale_update got=%0h exp=0", bp.update); end
        total++; if (bp.proto_err !== 1'b1) begin bad++; $display("FAIL fp_stale_err got=%0h exp=1", bp.proto_err); end
        total++; if (bp.br_count !== 32'd1 || bp.mp_count !== 32'd1) begin bad++; $display("FAIL fp_counts got=%0d/%0d exp=1/1", bp.br_count, bp.mp_count); end
    endtask

    task automatic test_reset_mid;
        push(32'h60, 1'b0);
        push(32'h64, 1'b0);
        push(32'h68, 1'b0);
        bp.ex_valid  = 1'b1;
        bp.ex_pc_in  = 32'h60;
        bp.ex_taken  = 1'b1;
        bp.ex_target = 32'h700;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        total++; if (bp.update !== 1'b0 || bp.flush !== 1'b0) begin bad++; $display("FAIL rm_pulses got=%0h/%0h exp=0/0", bp.update, bp.flush); end
        total++; if (bp.proto_err !== 1'b0) begin bad++; $display("FAIL rm_proto_err got=%0h exp=0", bp.proto_err); end
        total++; if (bp.br_count !== 32'd0 || bp.mp_count !== 32'd0) begin bad++; $display("FAIL rm_counts got=%0d/%0d exp=0/0", bp.br_count, bp.mp_count); end
        total++; if (bp.ex_pc !== 32'h0 || bp.redirect_pc !== 32'h0) begin bad++; $display("FAIL rm_pcs got=%0h/%0h exp=0/0", bp.ex_pc, bp.redirect_pc); end
        total++; if (bp.empty !== 1'b1 || bp.full !== 1'b0) begin bad++; $display("FAIL rm_empty got=%0h/%0h exp=1/0", bp.empty, bp.full); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle();
        test_reset();
        test_correct();
        test_mispredict_taken();
        test_mispredict_not_taken();
        test_full_back_to_back();
        test_flush_beats_push();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bp_resolve_queue.md
# bp_resolve_queue

In-order tracking queue that is the resolution end of the branch-predictor interface. It records every prediction issued at IF. At EX it retires the oldest entry against the actual branch outcome and produces the predictor update stream (`update`, `ex_pc`, `prev_mispredict`). It also produces the pipeline flush/redirect for mispredicts and keeps accuracy counters. It sits between the IF-stage predictor and the EX-stage branch comparator.

## Interface
- `DEPTH`, 4: entries in flight; power of two, ≥2.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `if_push`  in  1  IF issues a predicted control-flow instruction this cycle.
- `if_pc`  in  32  PC of that instruction.
- `if_p_tnt`  in  1  predictor output for `if_pc` (1 = taken).
- `ex_valid`  in  1  EX resolves the oldest outstanding branch this cycle.
- `ex_pc_in`  in  32  PC of the resolving branch.
- `ex_taken`  in  1  actual outcome.
- `ex_target`  in  32  actual taken target.
- `full`  out  1  queue full; IF must stall pushes.
- `empty`  out  1  queue empty.
- `update`  out  1  one-cycle pulse to the predictor.
- `ex_pc`  out  32  PC accompanying `update`.
- `prev_mispredict`  out  1  prediction ≠ outcome, valid with `update`.
- `flush`  out  1  one-cycle pulse: squash IF/ID and younger.
- `redirect_pc`  out  32  fetch target, valid with `flush`.
- `proto_err`  out  1  sticky protocol-error flag.
- `br_count`, `mp_count`  out  32  resolved-branch and mispredict counters.

## Operation
- Circular buffer of `{pc, p_tnt}` with head pointer, tail pointer and count. Pointer width is `$clog2(DEPTH)`; pointers wrap naturally.
- Push: `if_push && !full` writes the entry at tail and advances tail.
- Resolve: `ex_valid && !empty` reads the head and advances head.
  - `mis = head.p_tnt ^ ex_taken`.
  - Register `update=1`, `ex_pc=ex_pc_in`, `prev_mispredict=mis`.
  - `br_count++`. If `mis`, then `mp_count++`.
- On `mis`: register `flush=1`.
  - `redirect_pc = ex_taken ? ex_target : ex_pc_in+4`.
  - Clear the queue: head=tail=0, count=0.
- Simultaneous push and resolve without mispredict: both happen and count is unchanged. This is legal when full.
- Simultaneous push and resolve with mispredict: the push is wrong-path and is discarded. Flush wins.
- Push when full with no resolve: entry dropped, `proto_err` set.
- `ex_valid` when empty: ignored; no update, no counter change; `proto_err` set.
- `ex_pc_in != head.pc`: `proto_err` set. The resolve still completes normally using `ex_pc_in`.
- Counters wrap modulo 2^32.

## Timing
- Reset values:
  - `update`, `prev_mispredict`, `flush`, `proto_err` = 0.
  - `ex_pc`, `redirect_pc`, `br_count`, `mp_count` = 0.
  - Queue empty: `empty`=1, `full`=0.
- `full`/`empty` are combinational from the registered count; they update the cycle after the push/pop edge.
- Latency:
  - A pushed entry is resolvable from the next cycle.
  - `update`/`flush` rise one cycle after the `ex_valid` cycle.
  - Each pulse lasts exactly one cycle.
  - Back-to-back resolves give back-to-back `update` pulses.
- Queue clear on mispredict takes effect at the same edge that registers `flush`.
- Reset mid-operation: all in-flight entries are discarded and any pending `update`/`flush` is suppressed next cycle. `proto_err` and the counters clear.

## Structure
- Add `bp_entry_t` (`pc[31:0]`, `p_tnt`) to `rv32i_types`.
- One sub-module, `bp_track_fifo`: parametric storage with push, pop and sync clear; outputs head entry, full and empty.
- The top level holds the compare, flush/redirect registers, counters and error flag.

## Test plan
- Reset, push pc 0x100 `p_tnt`=1, resolve 0x100 taken → next cycle `update`=1, `ex_pc`=0x100, `prev_mispredict`=0, `flush`=0, `br_count`=1.
- Push 0x200 `p_tnt`=0, resolve taken with target 0x300 → `flush`=1, `redirect_pc`=0x300, `prev_mispredict`=1, `mp_count`=1, `empty`=1 next cycle.
- Push 0x400 `p_tnt`=1, resolve not-taken → `redirect_pc`=0x404, `flush`=1.
- Fill `DEPTH` entries → `full`=1. Then:
  - push and resolve together → still full, entries retire in order;
  - a fifth lone push → `proto_err`=1, dropped.
- Two queued entries, mispredict on the head with a simultaneous push → queue empty afterwards and the remaining `ex_valid` sets `proto_err`.
- Queue three entries, assert `rst` for one cycle → all outputs return to reset values and `empty`=1.
